// File: rtl/i2c_target.sv
// I2C target for 7-bit addressing: oversamples SCL/SDA, ACKs its own address and
// hands write bytes to / requests read bytes from the user logic. No clock stretching.
module i2c_target #(
  parameter logic [6:0] ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       wr_valid,
  output logic [7:0] wr_data,
  output logic       rd_req,
  input  logic [7:0] rd_data,
  output logic       busy,
  output logic       stop_det
);

  typedef enum logic [2:0] {
    k_idle,
    k_addr,
    k_addr_ack,
    k_write,
    k_write_ack,
    k_read,
    k_read_ack,
    k_ignore
  } state_t;

  logic [1:0] scl_sync, sda_sync;
  logic       scl_hist, sda_hist;
  logic       scl_s, sda_s;

  // Synchronizers reset to 1 so a released bus looks idle straight out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_hist <= 1'b1;
      sda_hist <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge value,
      // which is what turns these into a shift chain instead of a single wire.
      scl_sync <= {scl_sync[0], scl_in};
      sda_sync <= {sda_sync[0], sda_in};
      scl_hist <= scl_sync[1];
      sda_hist <= sda_sync[1];
    end
  end

  assign scl_s = scl_sync[1];
  assign sda_s = sda_sync[1];

  logic scl_rise, scl_fall, start_c, stop_c;

  assign scl_rise = scl_s & ~scl_hist;
  assign scl_fall = ~scl_s & scl_hist;
  assign start_c  = scl_s & scl_hist & sda_hist & ~sda_s;
  assign stop_c   = scl_s & scl_hist & ~sda_hist & sda_s;

  state_t     state, state_nxt;
  logic [2:0] bit_cnt, bit_cnt_nxt;
  logic [7:0] shreg, shreg_nxt;
  logic       byte_done, byte_done_nxt;
  logic       sda_oe_nxt, busy_nxt, wr_valid_nxt, rd_req_nxt, stop_det_nxt;
  logic [7:0] wr_data_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= k_idle;
      bit_cnt   <= '0;
      shreg     <= '0;
      byte_done <= 1'b0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      wr_valid  <= 1'b0;
      wr_data   <= '0;
      rd_req    <= 1'b0;
      stop_det  <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      shreg     <= shreg_nxt;
      byte_done <= byte_done_nxt;
      sda_oe    <= sda_oe_nxt;
      busy      <= busy_nxt;
      wr_valid  <= wr_valid_nxt;
      wr_data   <= wr_data_nxt;
      rd_req    <= rd_req_nxt;
      stop_det  <= stop_det_nxt;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt;
    shreg_nxt     = shreg;
    byte_done_nxt = byte_done;
    sda_oe_nxt    = sda_oe;
    busy_nxt      = busy;
    wr_data_nxt   = wr_data;
    wr_valid_nxt  = 1'b0;
    rd_req_nxt    = 1'b0;
    stop_det_nxt  = 1'b0;

    if (stop_c) begin
      state_nxt     = k_idle;
      sda_oe_nxt    = 1'b0;
      busy_nxt      = 1'b0;
      byte_done_nxt = 1'b0;
      stop_det_nxt  = 1'b1;
    end else if (start_c) begin
      state_nxt     = k_addr;
      bit_cnt_nxt   = '0;
      sda_oe_nxt    = 1'b0;
      busy_nxt      = 1'b0;
      byte_done_nxt = 1'b0;
    end else begin
      unique case (state)
        k_addr: begin
          if (scl_rise) begin
            shreg_nxt   = {shreg[6:0], sda_s};
            bit_cnt_nxt = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) byte_done_nxt = 1'b1;
          end else if (scl_fall && byte_done) begin
            byte_done_nxt = 1'b0;
            if (shreg[7:1] == ADDR) begin
              state_nxt  = k_addr_ack;
              sda_oe_nxt = 1'b1;
              busy_nxt   = 1'b1;
              rd_req_nxt = shreg[0];
            end else begin
              state_nxt  = k_ignore;
              sda_oe_nxt = 1'b0;
            end
          end
        end

        // shreg[0] still holds R/W here: nothing shifts during the ACK bit.
        k_addr_ack: begin
          if (scl_fall) begin
            bit_cnt_nxt = '0;
            if (!shreg[0]) begin
              sda_oe_nxt = 1'b0;
              state_nxt  = k_write;
            end else begin
              shreg_nxt  = rd_data;
              sda_oe_nxt = ~rd_data[7];
              state_nxt  = k_read;
            end
          end
        end

        k_write: begin
          if (scl_rise) begin
            shreg_nxt   = {shreg[6:0], sda_s};
            bit_cnt_nxt = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              byte_done_nxt = 1'b1;
              wr_data_nxt   = {shreg[6:0], sda_s};
              wr_valid_nxt  = 1'b1;
            end
          end else if (scl_fall && byte_done) begin
            byte_done_nxt = 1'b0;
            sda_oe_nxt    = 1'b1;
            state_nxt     = k_write_ack;
          end
        end

        k_write_ack: begin
          if (scl_fall) begin
            sda_oe_nxt = 1'b0;
            state_nxt  = k_write;
          end
        end

        k_read: begin
          if (scl_rise) begin
            bit_cnt_nxt = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) byte_done_nxt = 1'b1;
          end else if (scl_fall) begin
            if (byte_done) begin
              byte_done_nxt = 1'b0;
              sda_oe_nxt    = 1'b0;
              state_nxt     = k_read_ack;
            end else begin
              shreg_nxt  = {shreg[6:0], 1'b0};
              sda_oe_nxt = ~shreg[6];
            end
          end
        end

        // byte_done doubles as "controller ACKed" while waiting for the fall.
        k_read_ack: begin
          if (scl_rise) begin
            if (!sda_s) begin
              rd_req_nxt    = 1'b1;
              byte_done_nxt = 1'b1;
            end else begin
              busy_nxt  = 1'b0;
              state_nxt = k_ignore;
            end
          end else if (scl_fall && byte_done) begin
            byte_done_nxt = 1'b0;
            shreg_nxt     = rd_data;
            sda_oe_nxt    = ~rd_data[7];
            state_nxt     = k_read;
          end
        end

        k_ignore: sda_oe_nxt = 1'b0;

        k_idle: ;

        default: state_nxt = k_idle;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: a bit-banged I2C controller plus a transaction-level model
// of what the target must do (ACKs, write bytes, read bits, strobes, busy).
`timescale 1ns/1ps
module tb_i2c_target;

  localparam int         Q    = 5;  // quarter SCL period in clk cycles (SCL = clk/20)
  localparam logic [6:0] ADDR = 7'h50;

  logic       clk      = 1'b0;
  logic       reset_n  = 1'b0;
  logic       scl      = 1'b1;
  logic       ctrl_sda = 1'b1;
  logic       sda_bus;
  logic       sda_oe, wr_valid, rd_req, busy, stop_det;
  logic [7:0] wr_data;
  logic [7:0] rd_data = 8'h00;

  assign sda_bus = ctrl_sda & ~sda_oe;

  always #5 clk = ~clk;

  i2c_target #(.ADDR(ADDR)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .scl_in   (scl),
    .sda_in   (sda_bus),
    .sda_oe   (sda_oe),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .rd_req   (rd_req),
    .rd_data  (rd_data),
    .busy     (busy),
    .stop_det (stop_det)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model state: what the target must show during the current SCL-high phase,
  // and the strobes it still owes.
  logic       exp_oe = 1'b0, exp_busy = 1'b0, chk_en = 1'b0;
  int         hi_cnt = 0;
  logic [7:0] exp_wr_q[$];
  logic [7:0] obs_wr_q[$];
  logic [7:0] rd_src_q[$];
  logic [7:0] payload[$];
  int         rd_credit = 0, stop_credit = 0;
  int         rd_req_seen = 0, stop_seen = 0;

  // Compare process: runs every cycle, away from the active edge.
  always @(negedge clk) begin
    hi_cnt = scl ? hi_cnt + 1 : 0;
    if (reset_n) begin
      if (chk_en && scl && hi_cnt >= 5) begin
        check("sda_oe", sda_oe, exp_oe);
        check("busy", busy, exp_busy);
      end
      if (wr_valid) begin
        check("wr_valid pending", exp_wr_q.size() > 0, 1);
        if (exp_wr_q.size() > 0) check("wr_data", wr_data, exp_wr_q.pop_front());
        obs_wr_q.push_back(wr_data);
      end
      if (rd_req) begin
        rd_req_seen++;
        check("rd_req pending", rd_credit > 0, 1);
        check("rd_req with wr_valid", wr_valid, 1'b0);
        if (rd_credit > 0) rd_credit--;
      end
      if (stop_det) begin
        stop_seen++;
        check("stop_det pending", stop_credit > 0, 1);
        if (stop_credit > 0) stop_credit--;
      end
    end
  end

  // User logic: supply the next planned read byte on every request.
  always @(negedge clk) begin
    if (rd_req) rd_data = (rd_src_q.size() > 0) ? rd_src_q.pop_front() : 8'h00;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog");
  end

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic bit_slot(input logic drv, input logic e_oe, input logic e_busy,
                          output logic seen);
    clks(Q);
    ctrl_sda = drv;
    exp_oe   = e_oe;
    exp_busy = e_busy;
    clks(Q);
    scl    = 1'b1;
    chk_en = 1'b1;
    clks(Q);
    seen = sda_bus;
    clks(Q);
    chk_en = 1'b0;
    scl    = 1'b0;
  endtask

  task automatic start_cond();
    chk_en = 1'b0;
    if (!scl) begin
      clks(Q);
      ctrl_sda = 1'b1;
      clks(Q);
      scl = 1'b1;
      clks(Q);
    end
    ctrl_sda = 1'b0;
    clks(Q);
    scl = 1'b0;
  endtask

  task automatic stop_cond();
    clks(Q);
    ctrl_sda = 1'b0;
    clks(Q);
    scl = 1'b1;
    clks(Q);
    stop_credit++;
    ctrl_sda = 1'b1;
    clks(2 * Q);
  endtask

  task automatic addr_phase(input logic [7:0] a, output logic matched);
    logic s;
    matched = (a[7:1] == ADDR);
    if (matched && a[0]) rd_credit++;
    for (int i = 7; i >= 0; i--) bit_slot(a[i], 1'b0, 1'b0, s);
    bit_slot(1'b1, matched, matched, s);
    check("address ack", s, !matched);
  endtask

  task automatic write_byte(input logic [7:0] d, input logic on);
    logic s;
    if (on) exp_wr_q.push_back(d);
    for (int i = 7; i >= 0; i--) bit_slot(d[i], 1'b0, on, s);
    bit_slot(1'b1, on, on, s);
    check("data ack", s, !on);
  endtask

  task automatic read_byte(input logic [7:0] e, input logic on, input logic ack,
                           output logic [7:0] got);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_slot(1'b1, on ? ~e[i] : 1'b0, on, s);
      got[i] = s;
    end
    if (on) check("read byte", got, e);
    if (on && ack) rd_credit++;
    bit_slot(!ack, 1'b0, on && ack, s);
  endtask

  // START (or repeated START), address, then every byte in payload; the last
  // read byte is NACKed.
  task automatic run_xfer(input logic [7:0] a);
    logic       m;
    logic [7:0] got;
    if (a[0] && a[7:1] == ADDR) foreach (payload[i]) rd_src_q.push_back(payload[i]);
    start_cond();
    addr_phase(a, m);
    if (!a[0]) begin
      foreach (payload[i]) write_byte(payload[i], m);
    end else begin
      for (int i = 0; i < payload.size(); i++)
        read_byte(payload[i], m, i != payload.size() - 1, got);
    end
  endtask

  task automatic clear_obs();
    obs_wr_q.delete();
    rd_req_seen = 0;
    stop_seen   = 0;
  endtask

  initial begin
    logic       m, s;
    logic [7:0] a;
    logic [6:0] ra;

    clks(3);
    check("reset sda_oe", sda_oe, 1'b0);
    check("reset wr_valid", wr_valid, 1'b0);
    check("reset rd_req", rd_req, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset stop_det", stop_det, 1'b0);
    check("reset wr_data", wr_data, 8'h00);
    reset_n = 1'b1;
    clks(5);

    // Write 0x3C, 0xF1.
    clear_obs();
    payload = '{8'h3C, 8'hF1};
    run_xfer(8'hA0);
    stop_cond();
    check("t1 wr count", obs_wr_q.size(), 2);
    check("t1 wr byte0", obs_wr_q[0], 8'h3C);
    check("t1 wr byte1", obs_wr_q[1], 8'hF1);
    check("t1 stop count", stop_seen, 1);
    check("t1 busy after stop", busy, 1'b0);

    // Read 0x96 (ACK) then 0x5A (NACK).
    clear_obs();
    payload = '{8'h96, 8'h5A};
    run_xfer(8'hA1);
    check("t2 busy after nack", busy, 1'b0);
    stop_cond();
    check("t2 rd_req count", rd_req_seen, 2);
    check("t2 stop count", stop_seen, 1);

    // Address mismatch.
    clear_obs();
    payload = '{8'h00};
    run_xfer(8'hA2);
    stop_cond();
    check("t3 wr count", obs_wr_q.size(), 0);
    check("t3 rd_req count", rd_req_seen, 0);
    check("t3 stop count", stop_seen, 1);
    check("t3 busy", busy, 1'b0);

    // Write 0x12, repeated START, read 0x77.
    clear_obs();
    payload = '{8'h12};
    run_xfer(8'hA0);
    payload = '{8'h77};
    run_xfer(8'hA1);
    stop_cond();
    check("t4 wr count", obs_wr_q.size(), 1);
    check("t4 wr byte", obs_wr_q[0], 8'h12);
    check("t4 rd_req count", rd_req_seen, 1);

    // Reset while the target drives bit 7 = 0 of a read byte.
    clear_obs();
    rd_src_q.push_back(8'h3F);
    start_cond();
    addr_phase(8'hA1, m);
    clks(2 * Q);
    scl = 1'b1;
    clks(Q);
    check("t5 driving before reset", sda_oe, 1'b1);
    #3 reset_n = 1'b0;
    #1;
    check("t5 async sda_oe", sda_oe, 1'b0);
    check("t5 async busy", busy, 1'b0);
    rd_src_q.delete();
    rd_credit = 0;
    clks(3);
    reset_n = 1'b1;
    clks(60);
    check("t5 idle sda_oe", sda_oe, 1'b0);
    check("t5 idle busy", busy, 1'b0);
    check("t5 idle rd_req count", rd_req_seen, 1);
    payload = '{8'hA5};
    run_xfer(8'hA0);
    stop_cond();
    check("t5 wr count", obs_wr_q.size(), 1);
    check("t5 wr byte", obs_wr_q[0], 8'hA5);

    // START after three bits of a data byte.
    clear_obs();
    start_cond();
    addr_phase(8'hA0, m);
    bit_slot(1'b1, 1'b0, 1'b1, s);
    bit_slot(1'b1, 1'b0, 1'b1, s);
    bit_slot(1'b0, 1'b0, 1'b1, s);
    payload = '{8'h6B};
    run_xfer(8'hA0);
    stop_cond();
    check("t6 wr count", obs_wr_q.size(), 1);
    check("t6 wr byte", obs_wr_q[0], 8'h6B);

    // Randomised traffic, mixing STOP and repeated START between transfers.
    for (int t = 0; t < 30; t++) begin
      ra = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : ADDR;
      a  = {ra, 1'($urandom_range(0, 1))};
      payload.delete();
      repeat ($urandom_range(1, 4)) payload.push_back(8'($urandom));
      run_xfer(a);
      if ($urandom_range(0, 2) != 0) stop_cond();
    end
    stop_cond();
    clks(10);
    check("leftover write bytes", exp_wr_q.size(), 0);
    check("missing rd_req", rd_credit, 0);
    check("missing stop_det", stop_credit, 0);
    check("final busy", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
